// File: rtl/multiplier_pkg.sv
// Shared constants and types for the Kyber multiplier / modular reduction datapath.
package multiplier_pkg;

  localparam int DATA_LENGTH   = 32;
  localparam int KYBER_Q       = 3329;
  localparam int KYBER_COEFF_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUT
  } feeder_state_t;

endpackage

// File: rtl/kyber_pair_fifo.sv
// Synchronous FIFO for packed {a,b} coefficient pairs; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module kyber_pair_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kyber_pair_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW + 1)'(1);
      if (do_pop)  rptr <= rptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/kyber_mult_feeder.sv
// Buffers (a,b) pairs, forms a*b and serialises it through the shared reduction unit,
// returning (a*b) mod Q on a valid/ready stream. KYBER_FEEDER_STATS_EN adds pair/stall counters.
module kyber_mult_feeder #(
  parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH,
  parameter int COEFF_W     = multiplier_pkg::KYBER_COEFF_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int Q           = multiplier_pkg::KYBER_Q
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [COEFF_W-1:0]     a_i,
  input  logic [COEFF_W-1:0]     b_i,
  output logic                   red_start_o,
  output logic [DATA_LENGTH-1:0] red_x_o,
  output logic [DATA_LENGTH-1:0] red_m_o,
  input  logic [DATA_LENGTH-1:0] red_result_i,
  input  logic                   red_valid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [COEFF_W-1:0]     result_o,
  output logic                   range_err_o
`ifdef KYBER_FEEDER_STATS_EN
  ,
  output logic [31:0]            pair_cnt_o,
  output logic [31:0]            stall_cnt_o
`endif
);

  import multiplier_pkg::*;

  localparam int PW = 2 * COEFF_W;
  localparam logic [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(Q);

  if (DATA_LENGTH < 2 * COEFF_W) begin : g_bad_width
    $error("kyber_mult_feeder: DATA_LENGTH must be >= 2*COEFF_W");
  end

  feeder_state_t     state;
  feeder_state_t     state_nxt;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_nxt;
  logic [PW-1:0]     pair_prod;
  logic [COEFF_W-1:0] res;
  logic [COEFF_W-1:0] res_nxt;
  logic              range_err;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     fifo_rdata;
  logic [COEFF_W-1:0] fifo_a;
  logic [COEFF_W-1:0] fifo_b;
  logic              a_oor;
  logic              b_oor;
  logic              unused_res_hi;

  assign push       = in_valid_i && !fifo_full;
  assign in_ready_o = !fifo_full;

  kyber_pair_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  ({a_i, b_i}),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign fifo_a    = fifo_rdata[PW-1:COEFF_W];
  assign fifo_b    = fifo_rdata[COEFF_W-1:0];
  assign pair_prod = PW'(fifo_a) * PW'(fifo_b);

  // Out-of-range operands are still multiplied; the error flag only records that it happened.
  assign a_oor = {1'b0, a_i} >= Q_EXT;
  assign b_oor = {1'b0, b_i} >= Q_EXT;

  assign red_m_o       = DATA_LENGTH'(Q);
  assign red_x_o       = DATA_LENGTH'(prod);
  assign result_o      = res;
  assign range_err_o   = range_err;
  assign unused_res_hi = ^red_result_i[DATA_LENGTH-1:COEFF_W];

  always_comb begin
    state_nxt   = state;
    prod_nxt    = prod;
    res_nxt     = res;
    pop         = 1'b0;
    red_start_o = 1'b0;
    out_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          prod_nxt = pair_prod;
          // A zero product reduces to zero, so skip the reduction unit entirely.
          if (pair_prod == '0) begin
            res_nxt   = '0;
            state_nxt = OUT;
          end else begin
            state_nxt = START;
          end
        end
      end
      START: begin
        red_start_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (red_valid_i) begin
          res_nxt   = red_result_i[COEFF_W-1:0];
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      prod  <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      prod  <= prod_nxt;
      res   <= res_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      range_err <= 1'b0;
    end else if (push && (a_oor || b_oor)) begin
      range_err <= 1'b1;
    end
  end

`ifdef KYBER_FEEDER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pair_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (state == OUT && out_ready_i) pair_cnt_o <= pair_cnt_o + 32'd1;
      if (state == WAIT) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`else
  // Counters absent; the datapath does not depend on them.
`endif

endmodule
